// File: rtl/falc56_bus_ctrl_if.sv
// Host request/response and FALC56 pad-stage signals of falc56_bus_ctrl.
// slave = the bus controller, master = host logic plus pad stage.
interface falc56_bus_ctrl_if;
  logic       REQ_I;
  logic       WE_I;
  logic       CS_SEL_I;
  logic [7:0] ADDR_I;
  logic [7:0] WDATA_I;
  logic       BUSY_O;
  logic       ACK_O;
  logic [7:0] RDATA_O;
  logic [1:0] IRQ_O;
  logic [7:0] F56_BADD_I;
  logic       F56_BADD_DIR_O;
  logic [7:0] F56_BADD_O;
  logic       F56_ALE_O;
  logic       F56_RDn_O;
  logic       F56_WRn_O;
  logic [1:0] F56_CSn_O;
  logic [1:0] F56_INT_I;

  modport slave (
    input  REQ_I, WE_I, CS_SEL_I, ADDR_I, WDATA_I, F56_BADD_O, F56_INT_I,
    output BUSY_O, ACK_O, RDATA_O, IRQ_O, F56_BADD_I, F56_BADD_DIR_O,
           F56_ALE_O, F56_RDn_O, F56_WRn_O, F56_CSn_O
  );

  modport master (
    output REQ_I, WE_I, CS_SEL_I, ADDR_I, WDATA_I, F56_BADD_O, F56_INT_I,
    input  BUSY_O, ACK_O, RDATA_O, IRQ_O, F56_BADD_I, F56_BADD_DIR_O,
           F56_ALE_O, F56_RDn_O, F56_WRn_O, F56_CSn_O
  );
endinterface

// File: rtl/falc56_bus_ctrl.sv
// Turns single-beat host register requests into FALC56 Intel-style muxed bus cycles.
// Define FALC56_INT_SYNC_EN for synchronised, glitch-filtered interrupt outputs.
module falc56_bus_ctrl #(
  parameter int unsigned ALE_CYC = 2,
  parameter int unsigned STB_CYC = 4,
  parameter int unsigned REC_CYC = 2
) (
  input logic              CLK_I,
  input logic              RSTn_I,
  falc56_bus_ctrl_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_ALE, S_ADH, S_STB, S_REC} state_t;

  localparam logic [3:0] ALE_LD = 4'(ALE_CYC - 1);
  localparam logic [3:0] STB_LD = 4'(STB_CYC - 1);
  localparam logic [3:0] REC_LD = 4'(REC_CYC - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       we_q, we_d;
  logic [7:0] wdata_q, wdata_d;
  logic       busy_q, busy_d;
  logic       ack_q, ack_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] badd_q, badd_d;
  logic       dir_q, dir_d;
  logic       ale_q, ale_d;
  logic       rdn_q, rdn_d;
  logic       wrn_q, wrn_d;
  logic [1:0] csn_q, csn_d;
  logic [1:0] irq_q, irq_d;
`ifdef FALC56_INT_SYNC_EN
  logic [1:0] int_s1_q, int_s1_d;
  logic [1:0] int_s2_q, int_s2_d;
  logic [1:0] int_s3_q, int_s3_d;
  logic [1:0] int_agree;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    badd_d  = badd_q;
    dir_d   = dir_q;
    ale_d   = ale_q;
    rdn_d   = rdn_q;
    wrn_d   = wrn_q;
    csn_d   = csn_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.REQ_I) begin
          we_d    = bus.WE_I;
          wdata_d = bus.WDATA_I;
          busy_d  = 1'b1;
          cnt_d   = ALE_LD;
          csn_d   = bus.CS_SEL_I ? 2'b01 : 2'b10;
          ale_d   = 1'b1;
          badd_d  = bus.ADDR_I;
          dir_d   = 1'b1;
          state_d = S_ALE;
        end
      end
      S_ALE: begin
        if (cnt_q == 4'd0) begin
          ale_d   = 1'b0;
          state_d = S_ADH;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ADH: begin
        cnt_d   = STB_LD;
        state_d = S_STB;
        if (we_q) begin
          wrn_d  = 1'b0;
          badd_d = wdata_q;
          dir_d  = 1'b1;
        end else begin
          rdn_d = 1'b0;
          dir_d = 1'b0;
        end
      end
      S_STB: begin
        // Read data is sampled on the same edge that releases the strobe.
        if (cnt_q == 4'd0) begin
          rdn_d   = 1'b1;
          wrn_d   = 1'b1;
          cnt_d   = REC_LD;
          state_d = S_REC;
          if (!we_q) begin
            rdata_d = bus.F56_BADD_O;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_REC: begin
        // CSn is held through the first recovery clock only.
        csn_d = 2'b11;
        if (cnt_q == 4'd0) begin
          busy_d  = 1'b0;
          dir_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef FALC56_INT_SYNC_EN
    int_s1_d  = bus.F56_INT_I;
    int_s2_d  = int_s1_q;
    int_s3_d  = int_s2_q;
    int_agree = ~(int_s2_q ^ int_s3_q);
    irq_d     = (int_agree & int_s3_q) | (~int_agree & irq_q);
`else
    irq_d = bus.F56_INT_I;
`endif
  end

  always_ff @(posedge CLK_I or negedge RSTn_I) begin
    if (!RSTn_I) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      wdata_q  <= 8'h00;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= 8'h00;
      badd_q   <= 8'h00;
      dir_q    <= 1'b0;
      ale_q    <= 1'b0;
      rdn_q    <= 1'b1;
      wrn_q    <= 1'b1;
      csn_q    <= 2'b11;
      irq_q    <= 2'b00;
`ifdef FALC56_INT_SYNC_EN
      int_s1_q <= 2'b00;
      int_s2_q <= 2'b00;
      int_s3_q <= 2'b00;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      badd_q   <= badd_d;
      dir_q    <= dir_d;
      ale_q    <= ale_d;
      rdn_q    <= rdn_d;
      wrn_q    <= wrn_d;
      csn_q    <= csn_d;
      irq_q    <= irq_d;
`ifdef FALC56_INT_SYNC_EN
      int_s1_q <= int_s1_d;
      int_s2_q <= int_s2_d;
      int_s3_q <= int_s3_d;
`endif
    end
  end

  assign bus.BUSY_O         = busy_q;
  assign bus.ACK_O          = ack_q;
  assign bus.RDATA_O        = rdata_q;
  assign bus.IRQ_O          = irq_q;
  assign bus.F56_BADD_I     = badd_q;
  assign bus.F56_BADD_DIR_O = dir_q;
  assign bus.F56_ALE_O      = ale_q;
  assign bus.F56_RDn_O      = rdn_q;
  assign bus.F56_WRn_O      = wrn_q;
  assign bus.F56_CSn_O      = csn_q;

endmodule

// File: tb/tb_falc56_bus_ctrl.sv
// Bench for falc56_bus_ctrl: default-timing and swept-timing instances checked against a per-cycle timeline model.
// Interrupt expectations follow FALC56_INT_SYNC_EN as defined for the build.
module tb_falc56_bus_ctrl;

  typedef struct packed {
    logic       busy;
    logic       ack;
    logic [7:0] rdata;
    logic [7:0] badd;
    logic       dir;
    logic       ale;
    logic       rdn;
    logic       wrn;
    logic [1:0] csn;
  } obs_t;

  localparam obs_t RST_OBS = '{busy: 1'b0, ack: 1'b0, rdata: 8'h00, badd: 8'h00, dir: 1'b0,
                               ale: 1'b0, rdn: 1'b1, wrn: 1'b1, csn: 2'b11};
`ifdef FALC56_INT_SYNC_EN
  localparam bit SYNC_BUILD = 1'b1;
`else
  localparam bit SYNC_BUILD = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [7:0] last_rd_a;
  logic [7:0] last_rd_b;

  falc56_bus_ctrl_if ifa ();
  falc56_bus_ctrl_if ifb ();

  falc56_bus_ctrl dut_a (
    .CLK_I  (clk),
    .RSTn_I (rst_n),
    .bus    (ifa.slave)
  );

  falc56_bus_ctrl #(
    .ALE_CYC (1),
    .STB_CYC (15),
    .REC_CYC (1)
  ) dut_b (
    .CLK_I  (clk),
    .RSTn_I (rst_n),
    .bus    (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic obs_t obs_of(input bit b);
    obs_t o;
    if (b) begin
      o = '{busy: ifb.BUSY_O, ack: ifb.ACK_O, rdata: ifb.RDATA_O, badd: ifb.F56_BADD_I,
            dir: ifb.F56_BADD_DIR_O, ale: ifb.F56_ALE_O, rdn: ifb.F56_RDn_O,
            wrn: ifb.F56_WRn_O, csn: ifb.F56_CSn_O};
    end else begin
      o = '{busy: ifa.BUSY_O, ack: ifa.ACK_O, rdata: ifa.RDATA_O, badd: ifa.F56_BADD_I,
            dir: ifa.F56_BADD_DIR_O, ale: ifa.F56_ALE_O, rdn: ifa.F56_RDn_O,
            wrn: ifa.F56_WRn_O, csn: ifa.F56_CSn_O};
    end
    return o;
  endfunction

  // Expected bus state t clocks after the accepting edge, from the cycle timing rules.
  function automatic obs_t expect_at(input int t, input int a, input int s, input int r,
                                     input bit we, input bit sel, input logic [7:0] addr,
                                     input logic [7:0] wdata, input logic [7:0] pad,
                                     input logic [7:0] prev_rd);
    obs_t e;
    int   n;
    bit   strobe;
    n        = a + 1 + s + r;
    strobe   = (t >= a + 1) && (t < a + 1 + s);
    e.busy   = (t < n);
    e.ack    = (t == n);
    e.rdata  = (!we && t >= a + 1 + s) ? pad : prev_rd;
    e.dir    = we ? (t < n) : (t <= a);
    e.badd   = (t <= a) ? addr : wdata;
    e.ale    = (t < a);
    e.rdn    = !(strobe && !we);
    e.wrn    = !(strobe && we);
    e.csn    = (t < a + 2 + s) ? (sel ? 2'b01 : 2'b10) : 2'b11;
    return e;
  endfunction

  task automatic drive_req(input bit b, input logic req, input logic we, input logic sel,
                           input logic [7:0] addr, input logic [7:0] wdata);
    if (b) begin
      ifb.REQ_I = req; ifb.WE_I = we; ifb.CS_SEL_I = sel; ifb.ADDR_I = addr; ifb.WDATA_I = wdata;
    end else begin
      ifa.REQ_I = req; ifa.WE_I = we; ifa.CS_SEL_I = sel; ifa.ADDR_I = addr; ifa.WDATA_I = wdata;
    end
  endtask

  task automatic apply_stimulus(input bit b, input bit armed, input bit we, input bit sel,
                                input logic [7:0] addr, input logic [7:0] wdata,
                                input logic [7:0] pad, input int abort_t, input bit mid_req,
                                input string tag);
    int a, s, r, n;
    logic [7:0] prev;
    obs_t e, o;
    a    = b ? 1 : 2;
    s    = b ? 15 : 4;
    r    = b ? 1 : 2;
    n    = a + 1 + s + r;
    prev = b ? last_rd_b : last_rd_a;
    if (!armed) @(negedge clk);
    if (b) ifb.F56_BADD_O = pad; else ifa.F56_BADD_O = pad;
    drive_req(b, 1'b1, we, sel, addr, wdata);
    for (int t = 0; t <= n; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (t == 0) drive_req(b, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      if (mid_req && t == 2) drive_req(b, 1'b1, ~we, ~sel, ~addr, ~wdata);
      if (mid_req && t == 3) drive_req(b, 1'b0, we, sel, addr, wdata);
      e = expect_at(t, a, s, r, we, sel, addr, wdata, pad, prev);
      o = obs_of(b);
      if (!e.dir) begin
        e.badd = 8'h00;
        o.badd = 8'h00;
      end
      check_output($sformatf("%s t=%0d", tag, t), 32'(o), 32'(e));
      if (t == abort_t) begin
        rst_n = 1'b0;
        #1;
        check_output($sformatf("%s rst_async", tag), 32'(obs_of(b)), 32'(RST_OBS));
        @(posedge clk);
        @(negedge clk);
        check_output($sformatf("%s rst_hold", tag), 32'(obs_of(b)), 32'(RST_OBS));
        rst_n     = 1'b1;
        last_rd_a = 8'h00;
        last_rd_b = 8'h00;
        return;
      end
    end
    if (!we) begin
      if (b) last_rd_b = pad; else last_rd_a = pad;
    end
  endtask

  task automatic idle_check(input bit b, input int cycles, input string tag);
    obs_t o;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      o = obs_of(b);
      check_output($sformatf("%s idle%0d", tag, i), {30'b0, o.busy, o.ack}, 32'd0);
    end
  endtask

  initial begin
    bit         r_b, r_we, r_sel, r_arm;
    logic [7:0] r_addr, r_wdata, r_pad;
    n_checks  = 0;
    n_fail    = 0;
    last_rd_a = 8'h00;
    last_rd_b = 8'h00;
    rst_n     = 1'b0;
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_req(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    ifa.F56_BADD_O = 8'h00;
    ifb.F56_BADD_O = 8'h00;
    ifa.F56_INT_I  = 2'b00;
    ifb.F56_INT_I  = 2'b00;

    repeat (2) @(negedge clk);
    check_output("reset_a", 32'(obs_of(1'b0)), 32'(RST_OBS));
    check_output("reset_b", 32'(obs_of(1'b1)), 32'(RST_OBS));
    check_output("reset_irq", {30'b0, ifa.IRQ_O}, 32'd0);
    rst_n = 1'b1;
    idle_check(1'b0, 2, "post_reset");

    $display("[TB] directed write/read with default timing");
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h4C, 8'hA5, 8'h00, -1, 1'b0, "wr_4C");
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 8'h00, 8'h3C, -1, 1'b0, "rd_20");
    check_output("rdata_hold", 32'(ifa.RDATA_O), 32'h3C);

    $display("[TB] back-to-back and dropped mid-cycle request");
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 8'h00, 8'h96, -1, 1'b0, "b2b_rd");
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 8'h5A, 8'h00, -1, 1'b0, "b2b_wr");
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 8'hC3, 8'h00, -1, 1'b1, "midreq");
    idle_check(1'b0, 3, "midreq");

    $display("[TB] swept timing ALE=1 STB=15 REC=1");
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h7E, 8'h81, 8'h00, -1, 1'b0, "sweep_wr");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 8'hE7, -1, 1'b0, "sweep_rd");

    $display("[TB] randomized transactions");
    for (int i = 0; i < 10; i++) begin
      r_b     = 1'($urandom);
      r_we    = 1'($urandom);
      r_sel   = 1'($urandom);
      r_arm   = 1'($urandom);
      r_addr  = 8'($urandom);
      r_wdata = 8'($urandom);
      r_pad   = 8'($urandom);
      apply_stimulus(r_b, r_arm, r_we, r_sel, r_addr, r_wdata, r_pad, -1, 1'b0,
                     $sformatf("rnd%0d", i));
    end

    $display("[TB] reset during write strobe");
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 8'h99, 8'h00, 4, 1'b0, "abort_wr");
    idle_check(1'b0, 2, "abort");
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h45, 8'h00, 8'h5C, -1, 1'b0, "after_rst");

    $display("[TB] interrupt conditioning");
    @(negedge clk);
    ifa.F56_INT_I = 2'b01;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j == 1) ifa.F56_INT_I = 2'b00;
      check_output($sformatf("irq_glitch j=%0d", j), {30'b0, ifa.IRQ_O},
                   (!SYNC_BUILD && j == 1) ? 32'd1 : 32'd0);
    end
    ifa.F56_INT_I = 2'b11;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (!SYNC_BUILD || j >= 4)
        check_output($sformatf("irq_rise j=%0d", j), {30'b0, ifa.IRQ_O}, 32'd3);
      else if (j <= 2)
        check_output($sformatf("irq_rise j=%0d", j), {30'b0, ifa.IRQ_O}, 32'd0);
    end
    ifa.F56_INT_I = 2'b00;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (!SYNC_BUILD || j >= 4)
        check_output($sformatf("irq_fall j=%0d", j), {30'b0, ifa.IRQ_O}, 32'd0);
      else if (j <= 2)
        check_output($sformatf("irq_fall j=%0d", j), {30'b0, ifa.IRQ_O}, 32'd3);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
